// File: rtl/perceptron_pkg.sv
// Shared Q4.12 constants, FSM state encoding and the error-sign helper for the
// perceptron training sequencer.
package perceptron_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 12;

  localparam logic [DATA_W-1:0] ONE         = 16'h1000;
  localparam logic [DATA_W-1:0] DEFAULT_ETA = 16'h0400;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    EVAL      = 3'd2,
    UPDATE    = 3'd3,
    EPOCH_END = 3'd4,
    DONE      = 3'd5
  } state_t;

  // t - y as a 2-bit two's-complement value: +1 = 2'b01, -1 = 2'b11, 0 = 2'b00
  function automatic logic [1:0] class_error(input logic target, input logic y);
    if (target == y) return 2'b00;
    else if (target) return 2'b01;
    else return 2'b11;
  endfunction

endpackage

// File: rtl/perceptron_weight_update.sv
// Combinational learning-rule step for one weight: w_new = w + err*((x*eta)>>>12),
// wrapping modulo 2^16 like the perceptron datapath.
module perceptron_weight_update
  import perceptron_pkg::*;
(
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] eta,
  input  logic [1:0]        err,
  output logic [DATA_W-1:0] w_new
);

  logic signed [2*DATA_W-1:0] x_ext;
  logic signed [2*DATA_W-1:0] eta_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          delta;

  assign x_ext   = {{DATA_W{x[DATA_W-1]}}, x};
  assign eta_ext = {{DATA_W{eta[DATA_W-1]}}, eta};
  assign prod    = x_ext * eta_ext;
  assign delta   = DATA_W'(prod >>> FRAC_BITS);

  always_comb begin
    w_new = w;
    case (err)
      2'b01:   w_new = w + delta;
      2'b11:   w_new = w - delta;
      default: w_new = w;
    endcase
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Streams training samples into a 2-input perceptron and applies the perceptron
// learning rule through its weight load ports, epoch by epoch.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int               N_SAMPLES  = 4,
  parameter int               MAX_EPOCHS = 16,
  parameter logic [DATA_W-1:0] LEARN_RATE = DEFAULT_ETA,
  parameter int               CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] sample_x1,
  input  logic [DATA_W-1:0] sample_x2,
  input  logic              sample_target,
  output logic [DATA_W-1:0] IN1,
  output logic [DATA_W-1:0] IN2,
  input  logic              result,
  input  logic [DATA_W-1:0] weight1,
  input  logic [DATA_W-1:0] weight2,
  output logic [DATA_W-1:0] weight1_new,
  output logic [DATA_W-1:0] weight2_new,
  output logic              weight1_ld,
  output logic              weight2_ld,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [CNT_W-1:0]  epoch_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] LAST_EPOCH  = CNT_W'(MAX_EPOCHS - 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  sample_cnt;
  logic              target_r;
  logic              ld_r;
  logic [1:0]        err;
  logic [DATA_W-1:0] upd1, upd2;

  assign err = class_error(target_r, result);

  perceptron_weight_update u_upd1 (
    .w     (weight1),
    .x     (IN1),
    .eta   (LEARN_RATE),
    .err   (err),
    .w_new (upd1)
  );

  perceptron_weight_update u_upd2 (
    .w     (weight2),
    .x     (IN2),
    .eta   (LEARN_RATE),
    .err   (err),
    .w_new (upd2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = FETCH;
      FETCH:      if (sample_valid) next_state = EVAL;
      EVAL:       next_state = UPDATE;
      UPDATE:     next_state = (sample_cnt == LAST_SAMPLE) ? EPOCH_END : FETCH;
      EPOCH_END: begin
        if (err_count == '0 || epoch_count == LAST_EPOCH) next_state = DONE;
        else                                              next_state = FETCH;
      end
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    sample_ready = (state == FETCH);
    busy         = (state != IDLE) && (state != DONE);
    done         = (state == DONE);
  end

  // The ld strobe is registered in EVAL so it is high only during UPDATE;
  // an async reset in UPDATE drops it before the perceptron can load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IN1         <= '0;
      IN2         <= '0;
      target_r    <= 1'b0;
      weight1_new <= '0;
      weight2_new <= '0;
      ld_r        <= 1'b0;
      sample_cnt  <= '0;
      err_count   <= '0;
      epoch_count <= '0;
      converged   <= 1'b0;
    end else begin
      ld_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sample_cnt  <= '0;
            err_count   <= '0;
            epoch_count <= '0;
            converged   <= 1'b0;
          end
        end
        FETCH: begin
          if (sample_valid) begin
            IN1      <= sample_x1;
            IN2      <= sample_x2;
            target_r <= sample_target;
          end
        end
        EVAL: begin
          weight1_new <= upd1;
          weight2_new <= upd2;
          if (err != 2'b00) begin
            ld_r      <= 1'b1;
            err_count <= err_count + 1'b1;
          end
        end
        UPDATE: begin
          if (sample_cnt != LAST_SAMPLE) sample_cnt <= sample_cnt + 1'b1;
        end
        EPOCH_END: begin
          epoch_count <= epoch_count + 1'b1;
          if (err_count == '0) begin
            converged <= 1'b1;
          end else if (epoch_count != LAST_EPOCH) begin
            err_count  <= '0;
            sample_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign weight1_ld = ld_r;
  assign weight2_ld = ld_r;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed self-checking bench for perceptron_trainer; the bench plays the
// perceptron by driving result/weight1/weight2 per sample.
module tb_perceptron_trainer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_x1, sample_x2;
  logic        sample_target;
  logic [15:0] IN1, IN2;
  logic        result;
  logic [15:0] weight1, weight2;
  logic [15:0] weight1_new, weight2_new;
  logic        weight1_ld, weight2_ld;
  logic        busy, done, converged;
  logic [7:0]  epoch_count, err_count;

  int errors = 0;
  int checks = 0;

  perceptron_trainer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .sample_x1     (sample_x1),
    .sample_x2     (sample_x2),
    .sample_target (sample_target),
    .IN1           (IN1),
    .IN2           (IN2),
    .result        (result),
    .weight1       (weight1),
    .weight2       (weight2),
    .weight1_new   (weight1_new),
    .weight2_new   (weight2_new),
    .weight1_ld    (weight1_ld),
    .weight2_ld    (weight2_ld),
    .busy          (busy),
    .done          (done),
    .converged     (converged),
    .epoch_count   (epoch_count),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents a sample and the perceptron's view (result, weights); returns at
  // the negedge where the trainer is in EVAL.
  task automatic applyStimulus(input logic [15:0] x1, input logic [15:0] x2, input logic t,
                               input logic res, input logic [15:0] w1, input logic [15:0] w2);
    int waitCycles;
    waitCycles    = 0;
    result        = res;
    weight1       = w1;
    weight2       = w2;
    sample_x1     = x1;
    sample_x2     = x2;
    sample_target = t;
    while (!sample_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("sample_ready_wait", {31'd0, sample_ready}, 32'd1);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitCycles;
    logic [15:0] xv;
    rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0;
    sample_x1 = '0; sample_x2 = '0; sample_target = 1'b0;
    result = 1'b0; weight1 = '0; weight2 = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {31'd0, sample_ready}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_ld", {30'd0, weight1_ld, weight2_ld}, 32'd0);
    checkOutput("reset_epoch", {24'd0, epoch_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", {31'd0, sample_ready}, 32'd0);

    // Epoch with three wrong samples and one correct one
    pulseStart();
    checkOutput("start_busy", {31'd0, busy}, 32'd1);
    applyStimulus(16'h1000, 16'h1000, 1'b0, 1'b1, 16'h0000, 16'h0000);
    checkOutput("s1_in1", {16'd0, IN1}, 32'h1000);
    checkOutput("s1_eval_ld", {31'd0, weight1_ld}, 32'd0);
    @(negedge clk);
    checkOutput("s1_w1new", {16'd0, weight1_new}, 32'hFC00);
    checkOutput("s1_w2new", {16'd0, weight2_new}, 32'hFC00);
    checkOutput("s1_ld", {30'd0, weight1_ld, weight2_ld}, 32'd3);
    checkOutput("s1_err", {24'd0, err_count}, 32'd1);
    @(negedge clk);
    checkOutput("s1_ld_drop", {30'd0, weight1_ld, weight2_ld}, 32'd0);

    applyStimulus(16'hF000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("s2_w1new", {16'd0, weight1_new}, 32'h0400);
    checkOutput("s2_w2new", {16'd0, weight2_new}, 32'h0000);
    checkOutput("s2_err", {24'd0, err_count}, 32'd2);
    @(negedge clk);

    applyStimulus(16'h1000, 16'h0000, 1'b1, 1'b0, 16'h7E00, 16'h0000);
    @(negedge clk);
    checkOutput("s3_wrap_w1new", {16'd0, weight1_new}, 32'h8200);
    checkOutput("s3_err", {24'd0, err_count}, 32'd3);
    @(negedge clk);

    applyStimulus(16'h1000, 16'h2000, 1'b1, 1'b1, 16'h1234, 16'h5678);
    @(negedge clk);
    checkOutput("s4_ld", {30'd0, weight1_ld, weight2_ld}, 32'd0);
    checkOutput("s4_w1hold", {16'd0, weight1_new}, 32'h1234);
    checkOutput("s4_w2hold", {16'd0, weight2_new}, 32'h5678);
    @(negedge clk);
    checkOutput("epend_epoch", {24'd0, epoch_count}, 32'd0);
    checkOutput("epend_ready", {31'd0, sample_ready}, 32'd0);
    @(negedge clk);
    checkOutput("ep1_epoch", {24'd0, epoch_count}, 32'd1);
    checkOutput("ep1_err_clr", {24'd0, err_count}, 32'd0);
    checkOutput("ep1_ready", {31'd0, sample_ready}, 32'd1);

    // Asynchronous reset while the ld strobe is high
    applyStimulus(16'h1000, 16'h2000, 1'b0, 1'b1, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("rst_pre_ld", {31'd0, weight1_ld}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ld", {30'd0, weight1_ld, weight2_ld}, 32'd0);
    checkOutput("rst_in1", {16'd0, IN1}, 32'd0);
    checkOutput("rst_w1new", {16'd0, weight1_new}, 32'd0);
    checkOutput("rst_counts", {16'd0, epoch_count, err_count}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_idle_ready", {31'd0, sample_ready}, 32'd0);
    checkOutput("rst_idle_busy", {31'd0, busy}, 32'd0);

    // Converging epoch: result always matches target
    pulseStart();
    for (int i = 0; i < 4; i++) begin
      xv = 16'(16'h0100 * (i + 1));
      applyStimulus(xv, 16'h0300, i[0], i[0], 16'h0AAA, 16'h0BBB);
      @(negedge clk);
      checkOutput("conv_ld", {30'd0, weight1_ld, weight2_ld}, 32'd0);
      checkOutput("conv_w1new", {16'd0, weight1_new}, 32'h0AAA);
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("conv_done", {31'd0, done}, 32'd1);
    checkOutput("conv_converged", {31'd0, converged}, 32'd1);
    checkOutput("conv_epoch", {24'd0, epoch_count}, 32'd1);
    checkOutput("conv_err", {24'd0, err_count}, 32'd0);
    checkOutput("conv_busy", {31'd0, busy}, 32'd0);
    sample_x1 = 16'hAAAA;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    checkOutput("done_ignores_valid", {16'd0, IN1}, 32'h0400);
    checkOutput("done_held", {31'd0, done}, 32'd1);

    // Never converges: stops at the epoch limit
    pulseStart();
    checkOutput("fail_start_conv", {31'd0, converged}, 32'd0);
    checkOutput("fail_start_epoch", {24'd0, epoch_count}, 32'd0);
    for (int e = 0; e < 16; e++) begin
      for (int s = 0; s < 4; s++) begin
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000);
        @(negedge clk);
        @(negedge clk);
      end
      if (e == 0) begin
        @(negedge clk);
        checkOutput("fail_ep1_epoch", {24'd0, epoch_count}, 32'd1);
        checkOutput("fail_ep1_err", {24'd0, err_count}, 32'd0);
      end
    end
    waitCycles = 0;
    while (!done && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("fail_done", {31'd0, done}, 32'd1);
    checkOutput("fail_converged", {31'd0, converged}, 32'd0);
    checkOutput("fail_epoch", {24'd0, epoch_count}, 32'd16);
    checkOutput("fail_err", {24'd0, err_count}, 32'd4);

    pulseStart();
    checkOutput("restart_busy", {31'd0, busy}, 32'd1);
    checkOutput("restart_epoch", {24'd0, epoch_count}, 32'd0);
    checkOutput("restart_err", {24'd0, err_count}, 32'd0);
    checkOutput("restart_done", {31'd0, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
